// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer
//   Feeds the ALU's packed {opcode, A, B} vector one operation at a time.
//   A request is taken over a valid/ready port. The vector is held for the
//   opcode's latency, and then the ALU outputs are captured. The captured
//   values go back to the requester over a valid/ready response port.
//
// Ports
//   clk, reset_in                 clock (rising edge), async active-low reset
//   req_valid/req_ready           request handshake (ready only in IDLE)
//   req_opcode, req_a, req_b      operation and operands, sampled on accept
//   alu_opcode_inputs             registered {op,A,B} to the ALU, 0 = NOP
//   alu_final_output/carry/zero   ALU results
//   rsp_valid/rsp_ready           response handshake
//   rsp_result/carry/zero/err     captured results, err = unsupported opcode
//   ops_done                      completed response count, wraps
//
// state  | meaning
// -------+------------------------------------------------------------
// IDLE   | ready for a request, ALU vector is NOP
// WAIT   | vector held for the op latency, counting down to capture
// DONE   | response presented, waiting for rsp_ready
module alu_op_sequencer #(
  parameter int DATA_WIDTH    = 8,
  parameter int OPCODE_LENGTH = 4,
  parameter int LAT_FAST      = 1,
  parameter int LAT_MUL       = 4,
  parameter int LAT_DIV       = 8,
  parameter int VECTOR_LENGTH = OPCODE_LENGTH + 2*DATA_WIDTH
) (
  input  logic                     clk,
  input  logic                     reset_in,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [OPCODE_LENGTH-1:0] req_opcode,
  input  logic [DATA_WIDTH-1:0]    req_a,
  input  logic [DATA_WIDTH-1:0]    req_b,
  output logic [VECTOR_LENGTH-1:0] alu_opcode_inputs,
  input  logic [DATA_WIDTH-1:0]    alu_final_output,
  input  logic                     alu_carry_output,
  input  logic                     alu_zero_flag,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [DATA_WIDTH-1:0]    rsp_result,
  output logic                     rsp_carry,
  output logic                     rsp_zero,
  output logic                     rsp_err,
  output logic [15:0]              ops_done
);

  localparam int CNT_W = 16;

  localparam logic [OPCODE_LENGTH-1:0] OP_ADD  = OPCODE_LENGTH'(4'b0001);
  localparam logic [OPCODE_LENGTH-1:0] OP_SUB  = OPCODE_LENGTH'(4'b0010);
  localparam logic [OPCODE_LENGTH-1:0] OP_MUL  = OPCODE_LENGTH'(4'b0011);
  localparam logic [OPCODE_LENGTH-1:0] OP_DIV  = OPCODE_LENGTH'(4'b0100);
  localparam logic [OPCODE_LENGTH-1:0] OP_AND  = OPCODE_LENGTH'(4'b0110);
  localparam logic [OPCODE_LENGTH-1:0] OP_OR   = OPCODE_LENGTH'(4'b0111);
  localparam logic [OPCODE_LENGTH-1:0] OP_ZERO = OPCODE_LENGTH'(4'b1001);
  localparam logic [OPCODE_LENGTH-1:0] OP_GT   = OPCODE_LENGTH'(4'b1010);
  localparam logic [OPCODE_LENGTH-1:0] OP_EQ   = OPCODE_LENGTH'(4'b1011);
  localparam logic [OPCODE_LENGTH-1:0] OP_LT   = OPCODE_LENGTH'(4'b1100);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

  state_t                   state_q;
  logic [CNT_W-1:0]         cnt_q;
  logic [VECTOR_LENGTH-1:0] vec_q;
  logic                     req_ready_q;
  logic                     rsp_valid_q;
  logic [DATA_WIDTH-1:0]    rsp_result_q;
  logic                     rsp_carry_q;
  logic                     rsp_zero_q;
  logic                     rsp_err_q;
  logic [15:0]              ops_done_q;

  logic [CNT_W-1:0]         lat_d;
  logic                     supported_d;

  // Latency lookup for the opcode currently offered on the request port.
  always_comb begin
    lat_d       = '0;
    supported_d = 1'b1;
    case (req_opcode)
      OP_ADD, OP_SUB, OP_AND, OP_OR,
      OP_ZERO, OP_GT, OP_EQ, OP_LT: lat_d = CNT_W'(LAT_FAST);
      OP_MUL:                       lat_d = CNT_W'(LAT_MUL);
      OP_DIV:                       lat_d = CNT_W'(LAT_DIV);
      default:                      supported_d = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_in) begin
    if (!reset_in) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      vec_q        <= '0;
      req_ready_q  <= 1'b1;
      rsp_valid_q  <= 1'b0;
      rsp_result_q <= '0;
      rsp_carry_q  <= 1'b0;
      rsp_zero_q   <= 1'b0;
      rsp_err_q    <= 1'b0;
      ops_done_q   <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (req_valid) begin
            req_ready_q <= 1'b0;
            if (supported_d) begin
              vec_q   <= {req_opcode, req_a, req_b};
              cnt_q   <= lat_d;
              state_q <= S_WAIT;
            end else begin
              // Unsupported ops never reach the ALU; answer immediately.
              rsp_err_q    <= 1'b1;
              rsp_result_q <= '0;
              rsp_carry_q  <= 1'b0;
              rsp_zero_q   <= 1'b0;
              rsp_valid_q  <= 1'b1;
              state_q      <= S_DONE;
            end
          end
        end
        S_WAIT: begin
          // <= 1 rather than == 1 so a zero latency cannot stall forever.
          if (cnt_q <= CNT_W'(1)) begin
            rsp_result_q <= alu_final_output;
            rsp_carry_q  <= alu_carry_output;
            rsp_zero_q   <= alu_zero_flag;
            rsp_err_q    <= 1'b0;
            rsp_valid_q  <= 1'b1;
            vec_q        <= '0;
            cnt_q        <= '0;
            state_q      <= S_DONE;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        S_DONE: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            ops_done_q  <= ops_done_q + 16'd1;
            req_ready_q <= 1'b1;
            state_q     <= S_IDLE;
          end
        end
        default: begin
          state_q     <= S_IDLE;
          vec_q       <= '0;
          req_ready_q <= 1'b1;
          rsp_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign req_ready         = req_ready_q;
  assign alu_opcode_inputs = vec_q;
  assign rsp_valid         = rsp_valid_q;
  assign rsp_result        = rsp_result_q;
  assign rsp_carry         = rsp_carry_q;
  assign rsp_zero          = rsp_zero_q;
  assign rsp_err           = rsp_err_q;
  assign ops_done          = ops_done_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb_alu_op_sequencer
//   Bench for alu_op_sequencer. A behavioural ALU drives the alu_* inputs.
//   It returns real results only after the vector has been stable for the
//   opcode's latency, and 0xEE before that. Expected responses are queued
//   when a request is driven and compared when the response appears.
module tb_alu_op_sequencer;

  logic        clk = 1'b0;
  logic        reset_in;
  logic        req_valid;
  logic        req_ready;
  logic [3:0]  req_opcode;
  logic [7:0]  req_a, req_b;
  logic [19:0] alu_opcode_inputs;
  logic [7:0]  alu_final_output;
  logic        alu_carry_output, alu_zero_flag;
  logic        rsp_valid, rsp_ready;
  logic [7:0]  rsp_result;
  logic        rsp_carry, rsp_zero, rsp_err;
  logic [15:0] ops_done;

  int n_tests = 0;
  int n_fail  = 0;
  logic [15:0] exp_ops = 16'd0;

  typedef struct {
    logic [7:0]  res;
    logic        c, z, err;
    int          lat;
    logic [19:0] vec;
  } sb_t;
  sb_t sb_q[$];

  always #5 clk = ~clk;

  alu_op_sequencer dut (
    .clk(clk), .reset_in(reset_in),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_opcode(req_opcode), .req_a(req_a), .req_b(req_b),
    .alu_opcode_inputs(alu_opcode_inputs),
    .alu_final_output(alu_final_output),
    .alu_carry_output(alu_carry_output), .alu_zero_flag(alu_zero_flag),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .rsp_carry(rsp_carry), .rsp_zero(rsp_zero),
    .rsp_err(rsp_err), .ops_done(ops_done)
  );

  // ---------------- reference ALU ----------------
  function automatic logic [9:0] alu_fn(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
    logic [8:0]  s;
    logic [15:0] p;
    logic [7:0]  r;
    logic        c;
    r = 8'h00; c = 1'b0;
    case (op)
      4'b0001: begin s = {1'b0, a} + {1'b0, b}; r = s[7:0]; c = s[8]; end
      4'b0010: begin s = {1'b0, a} - {1'b0, b}; r = s[7:0]; c = s[8]; end
      4'b0011: begin p = {8'h00, a} * {8'h00, b}; r = p[7:0]; c = |p[15:8]; end
      4'b0100: r = (b == 8'h00) ? 8'hFF : a / b;
      4'b0110: r = a & b;
      4'b0111: r = a | b;
      4'b1001: r = 8'h00;
      4'b1010: r = {7'b0, a > b};
      4'b1011: r = {7'b0, a == b};
      4'b1100: r = {7'b0, a < b};
      default: r = 8'h00;
    endcase
    return {c, (r == 8'h00), r};
  endfunction

  function automatic int lat_fn(input logic [3:0] op);
    case (op)
      4'b0001, 4'b0010, 4'b0110, 4'b0111,
      4'b1001, 4'b1010, 4'b1011, 4'b1100: return 1;
      4'b0011: return 4;
      4'b0100: return 8;
      default: return 0;
    endcase
  endfunction

  logic [19:0] last_vec = 20'h0;
  int          age = 0;
  logic [9:0]  alu_out;

  // Age counts edges since the vector changed; updated off the active edge.
  always @(negedge clk) begin
    if (alu_opcode_inputs != last_vec) begin
      last_vec = alu_opcode_inputs;
      age = 1;
    end else if (age < 1000) begin
      age = age + 1;
    end
  end

  always_comb begin
    alu_out = 10'h0EE;
    if (age >= lat_fn(alu_opcode_inputs[19:16]))
      alu_out = alu_fn(alu_opcode_inputs[19:16], alu_opcode_inputs[15:8], alu_opcode_inputs[7:0]);
  end
  assign alu_carry_output = alu_out[9];
  assign alu_zero_flag    = alu_out[8];
  assign alu_final_output = alu_out[7:0];

  // ---------------- checking ----------------
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic sb_t expect_of(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
    sb_t e;
    logic [9:0] r;
    r = alu_fn(op, a, b);
    e.lat = lat_fn(op);
    if (e.lat == 0) begin
      e.res = 8'h00; e.c = 1'b0; e.z = 1'b0; e.err = 1'b1; e.vec = 20'h0;
    end else begin
      e.res = r[7:0]; e.c = r[9]; e.z = r[8]; e.err = 1'b0; e.vec = {op, a, b};
    end
    return e;
  endfunction

  // One full transaction. hold = cycles of rsp_ready=0 after rsp_valid,
  // during which a competing request is offered and must be held off.
  task automatic run_op(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b, input int hold);
    sb_t e, got_e;
    int  n;
    logic [7:0]  h_res;
    logic [15:0] ops_before;
    e = expect_of(op, a, b);
    @(negedge clk);
    n = 0;
    while (!req_ready && n < 50) begin @(negedge clk); n++; end
    chk("req_ready_before", {31'b0, req_ready}, 32'd1);
    req_valid = 1'b1; req_opcode = op; req_a = a; req_b = b; rsp_ready = 1'b0;
    sb_q.push_back(e);
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0; req_a = ~a; req_b = ~b; req_opcode = ~op;
    n = 0;
    while (!rsp_valid && n < 40) begin
      chk("vec_hold", {12'b0, alu_opcode_inputs}, {12'b0, e.vec});
      chk("req_ready_busy", {31'b0, req_ready}, 32'd0);
      @(negedge clk);
      n++;
    end
    chk("latency", n, e.lat);
    if (sb_q.size() == 0) begin
      chk("sb_underflow", 32'd1, 32'd0);
      return;
    end
    got_e = sb_q.pop_front();
    chk("rsp_result", {24'b0, rsp_result}, {24'b0, got_e.res});
    chk("rsp_carry",  {31'b0, rsp_carry},  {31'b0, got_e.c});
    chk("rsp_zero",   {31'b0, rsp_zero},   {31'b0, got_e.z});
    chk("rsp_err",    {31'b0, rsp_err},    {31'b0, got_e.err});
    chk("vec_cleared", {12'b0, alu_opcode_inputs}, 32'd0);
    h_res = rsp_result;
    ops_before = ops_done;
    for (int i = 0; i < hold; i++) begin
      req_valid = 1'b1; req_opcode = 4'b0001; req_a = 8'h11; req_b = 8'h22;
      @(negedge clk);
      chk("bp_valid",   {31'b0, rsp_valid}, 32'd1);
      chk("bp_result",  {24'b0, rsp_result}, {24'b0, h_res});
      chk("bp_ready",   {31'b0, req_ready}, 32'd0);
      chk("bp_vec",     {12'b0, alu_opcode_inputs}, 32'd0);
      chk("bp_ops",     {16'b0, ops_done}, {16'b0, ops_before});
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rsp_ready = 1'b0; req_valid = 1'b0;
    exp_ops = exp_ops + 16'd1;
    chk("ops_done", {16'b0, ops_done}, {16'b0, exp_ops});
    chk("rsp_valid_low", {31'b0, rsp_valid}, 32'd0);
    chk("req_ready_back", {31'b0, req_ready}, 32'd1);
  endtask

  // ---------------- stimulus ----------------
  logic [3:0] ops_tbl[10] = '{4'b0010, 4'b0010, 4'b0110, 4'b0111, 4'b1001,
                              4'b1010, 4'b1011, 4'b1100, 4'b0100, 4'b0000};
  logic [7:0] a_tbl[10]   = '{8'h10, 8'h05, 8'hF0, 8'h0F, 8'h77,
                              8'h80, 8'h33, 8'h01, 8'h64, 8'h12};
  logic [7:0] b_tbl[10]   = '{8'h01, 8'h09, 8'h3C, 8'hA0, 8'h12,
                              8'h7F, 8'h33, 8'h02, 8'h00, 8'h34};

  initial begin
    int seen;
    reset_in = 1'b0; req_valid = 1'b0; req_opcode = 4'h0; req_a = 8'h0; req_b = 8'h0;
    rsp_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_req_ready", {31'b0, req_ready}, 32'd1);
    chk("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    chk("rst_vec",       {12'b0, alu_opcode_inputs}, 32'd0);
    chk("rst_ops",       {16'b0, ops_done}, 32'd0);
    chk("rst_err",       {31'b0, rsp_err}, 32'd0);
    chk("rst_result",    {24'b0, rsp_result}, 32'd0);
    reset_in = 1'b1;

    run_op(4'b0001, 8'hFF, 8'h01, 0);
    chk("add_example_res", {24'b0, rsp_result}, 32'h00);
    chk("add_example_cz",  {30'b0, rsp_carry, rsp_zero}, 32'd3);

    run_op(4'b0011, 8'h09, 8'h05, 0);
    chk("mult_example_res", {24'b0, rsp_result}, 32'h2D);

    for (int i = 0; i < 10; i++) run_op(ops_tbl[i], a_tbl[i], b_tbl[i], 0);

    // DIV with 5 cycles of backpressure and a competing request.
    run_op(4'b0100, 8'hC8, 8'h07, 5);
    chk("div_example_res", {24'b0, rsp_result}, 32'd28);

    run_op(4'b0101, 8'hAA, 8'h55, 0);
    run_op(4'b1111, 8'h01, 8'h01, 2);

    for (int i = 0; i < 6; i++)
      run_op(4'($urandom_range(0, 15)), 8'($urandom), 8'($urandom), i % 3);

    // Reset in the middle of a DIV: no response afterwards.
    @(negedge clk);
    req_valid = 1'b1; req_opcode = 4'b0100; req_a = 8'h40; req_b = 8'h04;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("div_in_flight", {12'b0, alu_opcode_inputs}, 32'h44004);
    reset_in = 1'b0;
    #1;
    chk("midrst_vec",   {12'b0, alu_opcode_inputs}, 32'd0);
    chk("midrst_valid", {31'b0, rsp_valid}, 32'd0);
    chk("midrst_ops",   {16'b0, ops_done}, 32'd0);
    chk("midrst_ready", {31'b0, req_ready}, 32'd1);
    exp_ops = 16'd0;
    @(negedge clk);
    reset_in = 1'b1;
    rsp_ready = 1'b1;
    seen = 0;
    repeat (12) begin
      @(negedge clk);
      if (rsp_valid) seen++;
    end
    rsp_ready = 1'b0;
    chk("no_rsp_after_rst", seen, 0);

    run_op(4'b0111, 8'h0C, 8'h30, 0);

    // Counter wrap: preload near the top, then two more completions.
    @(negedge clk);
    dut.ops_done_q = 16'hFFFE;
    exp_ops = 16'hFFFE;
    run_op(4'b0001, 8'h01, 8'h02, 0);
    run_op(4'b0001, 8'h03, 8'h04, 0);
    chk("ops_wrap", {16'b0, ops_done}, 32'h0000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
